reed_muller_encode: RTL and testbench
=====================================

// Module: reed_muller_encode
// PURPOSE
//  Inner-code stage of the HQC concatenated encoder; sits directly downstream of the RS encoder.
//  - Takes the N1-bit RS codeword. Expands each byte into a 128-bit RM(1,7) codeword.
//  - Emits each RM codeword MULTIPLICITY times as a stream of 128-bit words with valid/ready.
//  - The stream feeds the v-vector accumulation in encap.
// PARAMETERS
//  parameter_set  "hqc128"  selects hqc128/hqc192/hqc256
//  N1_BYTES       46        RS symbols: 46/56/90
//  MULTIPLICITY   3         copies per RM codeword: 3/5/5
//  N1             8*N1_BYTES  width of the RS codeword input
//  RM_W           128       RM(1,7) codeword width
// PORTS
//  clk         in   1     clock
//  rst         in   1     asynchronous, active-high reset
//  start       in   1     request encode; sampled only in S_IDLE
//  cdw_in      in   N1    RS codeword; symbol i = cdw_in[8i+7:8i]
//  rm_word     out  128   current RM word; bit j = codeword bit j
//  rm_valid    out  1     rm_word is valid
//  rm_ready    in   1     consumer accepts the word; a transfer is rm_valid & rm_ready
//  busy        out  1     high from the start accept until done
//  done        out  1     one-cycle pulse after the final transfer
// BEHAVIOUR
//  Reset (async)
//  - state=S_IDLE, sym_cnt=0, rep_cnt=0.
//  - rm_valid=0, busy=0, done=0, rm_word=0. Symbol register cleared.
//  Encoding (m = symbol byte, j = bit index 0..127)
//  - c_j = m0 ^ (m1&j0) ^ (m2&j1) ^ (m3&j2) ^ (m4&j3) ^ (m5&j4) ^ (m7&j5) ^ (m6&j6).
//  FSM: S_IDLE -> S_EMIT -> S_DONE -> S_IDLE
//  - S_IDLE: on start, register cdw_in into the symbol shift register; sym_cnt=0, rep_cnt=0, go S_EMIT.
//  - S_EMIT: rm_valid=1. rm_word = encode(low byte of the shift register).
//    - rm_word is a registered function of state; it stays stable while rm_valid & !rm_ready.
//    - On transfer with rep_cnt<MULTIPLICITY-1: rep_cnt++.
//    - On transfer with rep_cnt==MULTIPLICITY-1: rep_cnt=0, shift the register right by 8, sym_cnt++.
//    - If sym_cnt==N1_BYTES-1 at that transfer: go S_DONE.
//  - S_DONE: rm_valid=0, done=1 for exactly one cycle, busy=0 next cycle, return to S_IDLE.
//  Timing and throughput
//  - Start accepted in cycle 0. First rm_valid in cycle 1.
//  - With rm_ready held high: one word per cycle, N1_BYTES*MULTIPLICITY words, no bubbles.
//  - Last word in cycle N1_BYTES*MULTIPLICITY. done in the cycle after it (hqc128: cycles 138 and 139).
//  Boundaries
//  - start while busy: ignored, no restart. start coincident with done: ignored; it is taken in the next S_IDLE cycle.
//  - rm_ready high while rm_valid low: no effect.
//  - cdw_in may change after the start cycle; it is captured once.
//  - rst mid-stream: aborts immediately to the reset values. No done pulse.
//  Counters: sym_cnt 7 bits, rep_cnt 3 bits. Neither wraps; both are cleared explicitly.
// CONFIGURATION
//  RM_ENC_LAST_EN
//  - Defined: adds output port rm_last (1 bit, reset 0).
//    - rm_last is high with rm_valid on the final word only (sym_cnt==N1_BYTES-1, rep_cnt==MULTIPLICITY-1).
//    - It is held with that word under backpressure.
//  - Undefined: the port is absent. End of stream is signalled by done only.
// STRUCTURE
//  Shared parameter package/include
//  - Per-parameter_set N1_BYTES and MULTIPLICITY, plus RM_W.
//  - State encodings S_IDLE/S_EMIT/S_DONE.
//  Sub-module rm17_encode_byte
//  - Purely combinational, 8-bit in, 128-bit out.
//  - Instantiated once. Reused later by the decoder-side re-encode check.
// TESTING
//  1. cdw_in=0, rm_ready=1, hqc128
//     -> 138 words of 0; rm_valid in cycles 1..138; done pulses in cycle 139; busy low in cycle 140.
//  2. Symbols 0x01 / 0x02 / 0x40 / 0x80
//     -> all-ones / 128'hAAAA...A / 128'hFFFFFFFF_FFFFFFFF_00000000_00000000 / 128'hFFFFFFFF_00000000_FFFFFFFF_00000000.
//     -> Each repeated exactly MULTIPLICITY times, in symbol order 0..N1_BYTES-1.
//  3. Random cdw_in, rm_ready random at 50% duty
//     -> stream matches the software model word-for-word.
//     -> rm_word and rm_valid stable across every stall; total transfers = N1_BYTES*MULTIPLICITY.
//  4. start pulsed in cycles 5 and 60 of a running encode, and coincident with done
//     -> no restart, no extra words; a second run starts in the S_IDLE cycle after done.
//  5. rst asserted asynchronously mid-run (hqc256, after 200 transfers)
//     -> rm_valid/busy/done are 0 immediately; a new start yields a correct full 450-word stream.
//  6. RM_ENC_LAST_EN defined, hqc192, random stalls
//     -> rm_last is high only on transfer 280, held during stalls on that word.

Source files
------------

// File: rtl/reed_muller_encode_pkg.sv
// Shared definitions for the HQC Reed-Muller inner encoder: parameter sets,
// FSM state encoding and the RM(1,7) generator rows.
package reed_muller_encode_pkg;

  typedef enum logic [1:0] {
    HQC128 = 2'd0,
    HQC192 = 2'd1,
    HQC256 = 2'd2
  } hqc_set_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int RM_W      = 128;
  localparam int SYM_CNT_W = 7;
  localparam int REP_CNT_W = 3;

  // Row t is the indicator of codeword positions j whose index bit t is set.
  localparam logic [RM_W-1:0] RM17_BASIS [7] = '{
    128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA,
    128'hCCCCCCCC_CCCCCCCC_CCCCCCCC_CCCCCCCC,
    128'hF0F0F0F0_F0F0F0F0_F0F0F0F0_F0F0F0F0,
    128'hFF00FF00_FF00FF00_FF00FF00_FF00FF00,
    128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000,
    128'hFFFFFFFF_00000000_FFFFFFFF_00000000,
    128'hFFFFFFFF_FFFFFFFF_00000000_00000000
  };

  function automatic int n1_bytes_of(input hqc_set_e s);
    case (s)
      HQC192:  return 56;
      HQC256:  return 90;
      default: return 46;
    endcase
  endfunction

  function automatic int multiplicity_of(input hqc_set_e s);
    case (s)
      HQC192:  return 5;
      HQC256:  return 5;
      default: return 3;
    endcase
  endfunction

endpackage

// File: rtl/reed_muller_encode_rm17_encode_byte.sv
// Combinational RM(1,7) encoder: one message byte to one 128-bit codeword.
// Shared with the decoder-side re-encode check.
module rm17_encode_byte
  import reed_muller_encode_pkg::*;
(
  input  logic [7:0]      msg,
  output logic [RM_W-1:0] code
);

  logic [6:0] sel;

  // Message bits 7 and 6 drive index bits 5 and 6 respectively (HQC ordering).
  assign sel = {msg[6], msg[7], msg[5:1]};

  always_comb begin
    code = {RM_W{msg[0]}};
    for (int t = 0; t < 7; t++) begin
      if (sel[t]) begin
        code = code ^ RM17_BASIS[t];
      end
    end
  end

endmodule

// File: rtl/reed_muller_encode.sv
// HQC inner-code stage: expands each RS symbol into an RM(1,7) codeword and
// streams it MULTIPLICITY times over valid/ready. Optional rm_last: RM_ENC_LAST_EN.
module reed_muller_encode
  import reed_muller_encode_pkg::*;
#(
  parameter hqc_set_e parameter_set = HQC128,
  parameter int       N1_BYTES      = n1_bytes_of(parameter_set),
  parameter int       MULTIPLICITY  = multiplicity_of(parameter_set),
  parameter int       N1            = 8 * N1_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N1-1:0]   cdw_in,
  output logic [RM_W-1:0] rm_word,
  output logic            rm_valid,
  input  logic            rm_ready,
  output logic            busy,
  output logic            done
`ifdef RM_ENC_LAST_EN
  ,
  output logic            rm_last
`endif
);

  localparam logic [SYM_CNT_W-1:0] SYM_LAST = SYM_CNT_W'(N1_BYTES - 1);
  localparam logic [REP_CNT_W-1:0] REP_LAST = REP_CNT_W'(MULTIPLICITY - 1);

  state_e                 state;
  state_e                 state_next;
  logic [N1-1:0]          sym_reg;
  logic [SYM_CNT_W-1:0]   sym_cnt;
  logic [REP_CNT_W-1:0]   rep_cnt;
  logic [RM_W-1:0]        enc_word;
  logic                   xfer;
  logic                   rep_wrap;
  logic                   sym_wrap;

  assign xfer     = (state == S_EMIT) && rm_ready;
  assign rep_wrap = (rep_cnt == REP_LAST);
  assign sym_wrap = (sym_cnt == SYM_LAST);

  rm17_encode_byte u_enc (
    .msg  (sym_reg[7:0]),
    .code (enc_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rm_valid   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        rm_valid = 1'b1;
        busy     = 1'b1;
        if (xfer && rep_wrap && sym_wrap) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The symbol register only moves on the last copy of a codeword, so the
  // encoded word is held steady for the whole duration of a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_reg <= '0;
      sym_cnt <= '0;
      rep_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sym_reg <= cdw_in;
            sym_cnt <= '0;
            rep_cnt <= '0;
          end
        end
        S_EMIT: begin
          if (xfer) begin
            if (rep_wrap) begin
              rep_cnt <= '0;
              sym_reg <= sym_reg >> 8;
              sym_cnt <= sym_cnt + SYM_CNT_W'(1);
            end else begin
              rep_cnt <= rep_cnt + REP_CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rm_word = rm_valid ? enc_word : '0;

`ifdef RM_ENC_LAST_EN
  assign rm_last = (state == S_EMIT) && sym_wrap && rep_wrap;
`endif

endmodule

// File: tb/tb_reed_muller_encode.sv
// Scoreboard bench for reed_muller_encode across hqc128/hqc192/hqc256 instances.
`timescale 1ns/1ps
module tb_reed_muller_encode;
  import reed_muller_encode_pkg::*;

  localparam int NINST = 3;
  localparam int MAXW  = 720;

  typedef struct {
    int           inst;
    logic [127:0] word;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             start    [NINST];
  logic             rdy      [NINST];
  logic [MAXW-1:0]  cdw      [NINST];
  logic [127:0]     word     [NINST];
  logic             valid    [NINST];
  logic             busy     [NINST];
  logic             done     [NINST];
`ifdef RM_ENC_LAST_EN
  logic             last     [NINST];
  logic             prev_last[NINST];
`endif
  int               nb_of    [NINST] = '{46, 56, 90};
  int               mult_of  [NINST] = '{3, 5, 5};
  int               xfer_cnt [NINST];
  logic             prev_stall[NINST];
  logic [127:0]     prev_word[NINST];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  for (genvar k = 0; k < NINST; k++) begin : g_dut
    localparam int NB = (k == 0) ? 46 : (k == 1) ? 56 : 90;
    reed_muller_encode #(.parameter_set(hqc_set_e'(k))) dut (
      .clk      (clock),
      .rst      (reset),
      .start    (start[k]),
      .cdw_in   (cdw[k][8*NB-1:0]),
      .rm_word  (word[k]),
      .rm_valid (valid[k]),
      .rm_ready (rdy[k]),
      .busy     (busy[k]),
      .done     (done[k])
`ifdef RM_ENC_LAST_EN
      ,
      .rm_last  (last[k])
`endif
    );
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: bit j is m0 xor the parity of the index bits selected by the message.
  function automatic logic [127:0] rm_model(input logic [7:0] m);
    logic [127:0] c;
    logic [6:0]   a;
    a = {m[6], m[7], m[5], m[4], m[3], m[2], m[1]};
    for (int j = 0; j < 128; j++) begin
      c[j] = m[0] ^ ($countones(a & 7'(j)) % 2 == 1);
    end
    return c;
  endfunction

  task automatic push_expected(input int k, input logic [MAXW-1:0] data);
    exp_t e;
    for (int s = 0; s < nb_of[k]; s++) begin
      for (int r = 0; r < mult_of[k]; r++) begin
        e.inst = k;
        e.word = rm_model(data[8*s +: 8]);
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic logic [MAXW-1:0] rand_data();
    logic [MAXW-1:0] d;
    for (int i = 0; i < MAXW / 32; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  // Monitor: every transfer pops one expected word; stalls must hold the word.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      for (int k = 0; k < NINST; k++) prev_stall[k] = 1'b0;
    end else begin
      for (int k = 0; k < NINST; k++) begin
        if (prev_stall[k]) begin
          checkOutput("stall_valid", valid[k], 1);
          checkOutput("stall_word", word[k], prev_word[k]);
`ifdef RM_ENC_LAST_EN
          checkOutput("stall_last", last[k], prev_last[k]);
`endif
        end
        if (valid[k] && rdy[k]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL extra_word: inst %0d got %h, required no word", k, word[k]);
          end else begin
            e = exp_q.pop_front();
            checkOutput("word_inst", k, e.inst);
            checkOutput($sformatf("word[%0d]#%0d", k, xfer_cnt[k]), word[k], e.word);
          end
`ifdef RM_ENC_LAST_EN
          checkOutput("rm_last", last[k], xfer_cnt[k] == nb_of[k] * mult_of[k] - 1);
`endif
          xfer_cnt[k]++;
        end
        prev_stall[k] = valid[k] && !rdy[k];
        prev_word[k]  = word[k];
`ifdef RM_ENC_LAST_EN
        prev_last[k]  = last[k];
`endif
      end
    end
  end

  // Drives one encode (or, with second set, an encode plus stray starts and a
  // back-to-back restart) and checks the control outputs cycle by cycle.
  task automatic applyStimulus(input int k, input logic [MAXW-1:0] data, input bit rand_ready,
                               input bit timing, input bit second);
    int total;
    int last_done;
    int budget;
    int cyc;
    bit exp_v;
    bit exp_d;
    bit finished;
    total     = nb_of[k] * mult_of[k];
    last_done = second ? 2 * total + 3 : total + 1;
    budget    = 8 * total + 40;
    finished  = 1'b0;
    xfer_cnt[k] = 0;
    cdw[k]   = data;
    start[k] = 1'b1;
    rdy[k]   = 1'b1;
    @(posedge clock) #1;
    start[k] = 1'b0;
    if (!second) cdw[k] = rand_data();
    cyc = 1;
    while (cyc < budget && !finished) begin
      rdy[k] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (second) start[k] = (cyc == 5 || cyc == 60 || cyc == total + 1 || cyc == total + 2);
      if (timing) begin
        exp_v = (cyc >= 1 && cyc <= total) || (second && cyc >= total + 3 && cyc <= 2 * total + 2);
        exp_d = (cyc == total + 1) || (second && cyc == 2 * total + 3);
        checkOutput($sformatf("valid@%0d", cyc), valid[k], exp_v);
        checkOutput($sformatf("done@%0d", cyc), done[k], exp_d);
        checkOutput($sformatf("busy@%0d", cyc), busy[k], exp_v | exp_d);
        if (cyc == last_done + 1) finished = 1'b1;
      end else if (done[k]) begin
        @(posedge clock) #1;
        checkOutput("done_pulse", done[k], 0);
        checkOutput("busy_after_done", busy[k], 0);
        finished = 1'b1;
      end
      if (!finished) begin
        @(posedge clock) #1;
        cyc++;
      end
    end
    start[k] = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: inst %0d stopped at cycle %0d, required done within %0d", k, cyc, budget);
    end
    checkOutput("transfers", xfer_cnt[k], second ? 2 * total : total);
    checkOutput("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [MAXW-1:0] data;
    logic [7:0]      pat_byte [4] = '{8'h01, 8'h02, 8'h40, 8'h80};
    logic [127:0]    pat_word [4] = '{
      128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
      128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA,
      128'hFFFFFFFF_FFFFFFFF_00000000_00000000,
      128'hFFFFFFFF_00000000_FFFFFFFF_00000000
    };
    exp_t e;

    reset = 1'b1;
    for (int k = 0; k < NINST; k++) begin
      start[k] = 1'b0;
      rdy[k]   = 1'b1;
      cdw[k]   = '0;
      xfer_cnt[k] = 0;
    end
    #1;
    for (int k = 0; k < NINST; k++) begin
      checkOutput("reset_valid", valid[k], 0);
      checkOutput("reset_busy", busy[k], 0);
      checkOutput("reset_done", done[k], 0);
      checkOutput("reset_word", word[k], 0);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    $display("[TB] zero codeword, hqc128, exact timing");
    push_expected(0, '0);
    applyStimulus(0, '0, 1'b0, 1'b1, 1'b0);

    $display("[TB] basis symbols, hqc128 and hqc256");
    for (int k = 0; k < NINST; k += 2) begin
      data = '0;
      for (int s = 0; s < nb_of[k]; s++) begin
        data[8*s +: 8] = pat_byte[s % 4];
        for (int r = 0; r < mult_of[k]; r++) begin
          e.inst = k;
          e.word = pat_word[s % 4];
          exp_q.push_back(e);
        end
      end
      applyStimulus(k, data, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] random codewords with random backpressure");
    for (int k = 0; k < NINST; k++) begin
      repeat (2) begin
        data = rand_data();
        push_expected(k, data);
        applyStimulus(k, data, 1'b1, 1'b0, 1'b0);
      end
    end

    $display("[TB] stray starts and restart right after done");
    data = rand_data();
    push_expected(0, data);
    push_expected(0, data);
    applyStimulus(0, data, 1'b0, 1'b1, 1'b1);

    $display("[TB] asynchronous reset mid-stream, hqc256");
    data = rand_data();
    push_expected(2, data);
    xfer_cnt[2] = 0;
    cdw[2]   = data;
    start[2] = 1'b1;
    rdy[2]   = 1'b1;
    @(posedge clock) #1;
    start[2] = 1'b0;
    repeat (200) @(posedge clock);
    #1;
    checkOutput("xfers_before_abort", xfer_cnt[2], 200);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_valid", valid[2], 0);
    checkOutput("abort_busy", busy[2], 0);
    checkOutput("abort_done", done[2], 0);
    checkOutput("abort_word", word[2], 0);
    exp_q.delete();
    #4 reset = 1'b0;
    data = rand_data();
    push_expected(2, data);
    applyStimulus(2, data, 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
